serial_add_ctrl: RTL and testbench

//  Sequencer that time-shares one half-adder cell to perform a W-bit add with carry-in.

---
 rtl/serial_add_pkg.sv | 5 +
 rtl/serial_add_ctrl_ha.sv | 10 +
 rtl/serial_add_ctrl.sv | 88 ++++++++
 tb/tb_serial_add_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and limits for the serial adder sequencer
package serial_add_pkg;
  localparam int W_MAX = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, PH1 = 2'd1, PH2 = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/serial_add_ctrl_ha.sv
// HalfAdder: single-bit half-adder cell shared by the serial adder
module HalfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: W-bit add with carry-in on one time-shared half-adder, two steps per bit; optional SERIAL_ADD_OVF_EN adds signed overflow output ovf
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic         ovf,
`endif
  output logic         cout
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  state_t state;
  logic [IW-1:0] idx;
  logic [W-1:0] a_q, b_q, a_sh, b_sh;
  logic carry, s1, c1, ha_a, ha_b, ha_s, ha_co, last;
  assign a_sh  = a_q >> idx;
  assign b_sh  = b_q >> idx;
  assign ha_a  = (state == PH1) ? a_sh[0] : s1;
  assign ha_b  = (state == PH1) ? b_sh[0] : carry;
  assign last  = idx == IW'(W - 1);
  assign ready = state == IDLE;
  assign busy  = (state == PH1) || (state == PH2);
  assign done  = state == DONE;
  HalfAdder u_ha (.a(ha_a), .b(ha_b), .s(ha_s), .co(ha_co));
  // Sequencer: PH1 adds the operand bits, PH2 folds in the running carry and writes the sum bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      s1    <= 1'b0;
      c1    <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          carry <= cin;
          sum   <= '0;
          cout  <= 1'b0;
          idx   <= '0;
`ifdef SERIAL_ADD_OVF_EN
          ovf   <= 1'b0;
`endif
          state <= PH1;
        end
        PH1: begin
          s1    <= ha_s;
          c1    <= ha_co;
          state <= PH2;
        end
        PH2: begin
          sum   <= sum | (W'(ha_s) << idx);
          carry <= c1 | ha_co;
          if (last) begin
            cout  <= c1 | ha_co;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= carry ^ (c1 | ha_co);
`endif
            state <= DONE;
          end else begin
            idx   <= idx + IW'(1);
            state <= PH1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboarded random and directed checks of serial_add_ctrl at W=4, W=1 and W=8
module tb_serial_add_ctrl;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic start4 = 0, cin4 = 0, ready4, busy4, done4, cout4;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  logic start1 = 0, cin1 = 0, ready1, busy1, done1, cout1;
  logic [0:0] a1 = 0, b1 = 0, sum1;
  logic start8 = 0, cin8 = 0, ready8, busy8, done8, cout8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  int q4[$], q1[$], q8[$];
`ifdef SERIAL_ADD_OVF_EN
  logic ovf4, ovf1, ovf8;
  bit o4[$], o1[$], o8[$];
`endif
  serial_add_ctrl #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf4),
`endif
    .cout(cout4));
  serial_add_ctrl #(.W(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf1),
`endif
    .cout(cout1));
  serial_add_ctrl #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf8),
`endif
    .cout(cout8));
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask
  function automatic bit sovf(input int av, input int bv, input int ci, input int w);
    int sa, sb, s;
    sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    s = sa + sb + ci;
    return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
  endfunction
  // scoreboard monitors: pop the expected result whenever a DUT signals done
  always @(negedge clk) if (done4) begin
    if (q4.size() == 0) begin
      checks++; failures++;
      $display("FAIL w4_spurious_done got=%0d expected=no_result", {cout4, sum4});
    end else begin
      chk("w4_result", int'({cout4, sum4}), q4.pop_front());
`ifdef SERIAL_ADD_OVF_EN
      chk("w4_ovf", int'(ovf4), int'(o4.pop_front()));
`endif
    end
  end
  always @(negedge clk) if (done1) begin
    if (q1.size() == 0) begin
      checks++; failures++;
      $display("FAIL w1_spurious_done got=%0d expected=no_result", {cout1, sum1});
    end else begin
      chk("w1_result", int'({cout1, sum1}), q1.pop_front());
`ifdef SERIAL_ADD_OVF_EN
      chk("w1_ovf", int'(ovf1), int'(o1.pop_front()));
`endif
    end
  end
  always @(negedge clk) if (done8) begin
    if (q8.size() == 0) begin
      checks++; failures++;
      $display("FAIL w8_spurious_done got=%0d expected=no_result", {cout8, sum8});
    end else begin
      chk("w8_result", int'({cout8, sum8}), q8.pop_front());
`ifdef SERIAL_ADD_OVF_EN
      chk("w8_ovf", int'(ovf8), int'(o8.pop_front()));
`endif
    end
  end
  task automatic add4(input logic [3:0] av, input logic [3:0] bv, input logic ci, input bit inj);
    int n;
    @(negedge clk);
    chk("w4_ready_before", int'(ready4), 1);
    a4 = av; b4 = bv; cin4 = ci; start4 = 1;
    q4.push_back(int'(av) + int'(bv) + int'(ci));
`ifdef SERIAL_ADD_OVF_EN
    o4.push_back(sovf(int'(av), int'(bv), int'(ci), 4));
`endif
    @(posedge clk); #1;
    start4 = 0; a4 = ~av; b4 = ~bv; cin4 = ~ci;
    n = 0;
    while (!done4 && n < 40) begin
      if (n == 1) chk("w4_busy", int'(busy4), 1);
      if (inj && n == 3) begin start4 = 1; a4 = 4'h9; b4 = 4'h9; end
      if (inj && n == 4) start4 = 0;
      @(posedge clk); #1; n++;
    end
    chk("w4_latency", n, 8);
    @(posedge clk); #1;
    chk("w4_ready_after", int'(ready4), 1);
  endtask
  task automatic add1(input logic av, input logic bv, input logic ci);
    int n;
    @(negedge clk);
    a1 = av; b1 = bv; cin1 = ci; start1 = 1;
    q1.push_back(int'(av) + int'(bv) + int'(ci));
`ifdef SERIAL_ADD_OVF_EN
    o1.push_back(sovf(int'(av), int'(bv), int'(ci), 1));
`endif
    @(posedge clk); #1;
    start1 = 0;
    n = 0;
    while (!done1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("w1_latency", n, 2);
    @(posedge clk); #1;
  endtask
  initial begin
    int pushed, cyc;
    #12;
    chk("rst_ready", int'(ready4), 1);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_sum", int'({cout4, sum4}), 0);
    @(negedge clk); rst_n = 1;
    add4(4'h3, 4'h5, 1'b0, 0);
    add4(4'hF, 4'hF, 1'b1, 0);
    add4(4'h7, 4'h1, 1'b0, 0);
    add4(4'hA, 4'h4, 1'b1, 1);
    chk("w4_held_sum", int'({cout4, sum4}), 5'h0F);
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h0; cin4 = 0; start4 = 1;
    @(posedge clk); #1;
    start4 = 0;
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_ready", int'(ready4), 1);
    chk("midrst_busy", int'(busy4), 0);
    chk("midrst_done", int'(done4), 0);
    chk("midrst_sum", int'({cout4, sum4}), 0);
    @(negedge clk); rst_n = 1;
    add4(4'hC, 4'h9, 1'b0, 0);
    add1(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) add1(i[0], i[1], i[2]);
    pushed = 0; cyc = 0;
    while (pushed < 1000 && cyc < 40000) begin
      @(negedge clk); cyc++;
      if (ready8) begin
        a8 = (pushed == 0) ? 8'hFF : (pushed == 1) ? 8'h00 : 8'($urandom);
        b8 = (pushed == 0) ? 8'hFF : (pushed == 1) ? 8'h00 : 8'($urandom);
        cin8 = (pushed == 0) ? 1'b1 : (pushed == 1) ? 1'b0 : 1'($urandom);
        start8 = 1;
        q8.push_back(int'(a8) + int'(b8) + int'(cin8));
`ifdef SERIAL_ADD_OVF_EN
        o8.push_back(sovf(int'(a8), int'(b8), int'(cin8), 8));
`endif
        pushed++;
      end
    end
    chk("w8_issued", pushed, 1000);
    @(negedge clk); start8 = 0;
    cyc = 0;
    while ((q8.size() != 0 || q4.size() != 0 || q1.size() != 0) && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
